y_writer: RTL and testbench
===========================

Y_WRITER -- requirements
Module: y_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output buffer entries (power of two).
REQ-002 Parameter LOG2_FIFO_DEPTH, default 4, log2(FIFO_DEPTH).
REQ-003 Parameter AF_THRESHOLD, default 12, occupancy at which almost_full asserts.
REQ-004 Parameter ADDR_WIDTH, default 48, memory byte-address width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse; latch base_addr, clear counters, begin a matrix pass.
REQ-009 base_addr  input  ADDR_WIDTH  byte address of y[0].
REQ-010 push  input  1  result valid from intermediator push_to_y.
REQ-011 v  input  66  FloPoCo double from intermediator v_to_y: [65:64] exception, [63] sign, [62:52] exponent, [51:0] fraction.
REQ-012 eof  input  1  one-cycle pulse; no further push in this pass.
REQ-013 almost_full  output  1  upstream must stop pushing.
REQ-014 mem_req  output  1  write request valid, one cycle per entry.
REQ-015 mem_addr  output  ADDR_WIDTH  write byte address.
REQ-016 mem_data  output  64  IEEE-754 double.
REQ-017 mem_stall  input  1  memory cannot accept a request this cycle.
REQ-018 rows_written  output  32  requests issued this pass.
REQ-019 done  output  1  pass complete, held until start or rst.
REQ-020 overflow  output  1  sticky: push dropped (FIFO full or not RUN).

Function
REQ-021 States IDLE, RUN, FLUSH, DONE; rst -> IDLE.
REQ-022 start in any state -> RUN; clears rows_written, done, overflow; latches base_addr; FIFO is not flushed.
REQ-023 RUN + eof -> FLUSH; push in the same cycle as eof is accepted.
REQ-024 FLUSH -> DONE on the cycle FIFO is empty and no mem_req is in the output register; done=1 from the following cycle.
REQ-025 push accepted only in RUN (or the eof cycle) with FIFO occupancy < FIFO_DEPTH; otherwise dropped and overflow set.
REQ-026 Full is evaluated on pre-pop occupancy; push and pop in the same cycle at occupancy FIFO_DEPTH drops the push.
REQ-027 almost_full = (occupancy >= AF_THRESHOLD), registered, combinationally independent of push.
REQ-028 Format conversion at enqueue: exc 00 -> {sign,63'b0}; 01 -> {sign,exp,frac}; 10 -> {sign,11'h7FF,52'b0}; 11 -> 64'h7FF8000000000000.
REQ-029 Pop when FIFO non-empty and mem_stall=0; popped entry registered onto mem_req/mem_data/mem_addr next cycle.
REQ-030 Latency: push in cycle N with empty FIFO and mem_stall low -> mem_req high in cycle N+2.
REQ-031 mem_stall=1 -> no pop, mem_req=0 next cycle; a request already presented is not repeated.
REQ-032 mem_addr = base_addr + 8*rows_written (pre-increment), modulo 2^ADDR_WIDTH; rows_written increments per mem_req, wraps at 2^32.
REQ-033 Order of mem_data equals order of accepted pushes.

Reset
REQ-034 rst: state IDLE, FIFO empty, mem_req=0, mem_addr=0, mem_data=0, rows_written=0, done=0, overflow=0, almost_full=0.
REQ-035 rst mid-pass discards all FIFO contents and the pending request; no mem_req in the cycle after rst.

Verification
REQ-036 start base 0x1000, push 3 values exc=01, eof, mem_stall=0 -> mem_req at addresses 0x1000, 0x1008, 0x1010, rows_written=3, done=1.
REQ-037 push exc 00 sign 1, exc 10 sign 0, exc 11 -> mem_data 0x8000000000000000, 0x7FF0000000000000, 0x7FF8000000000000.
REQ-038 mem_stall=1, push 12 -> almost_full=1 after 12th; push 4 more -> no overflow; 17th -> overflow=1; release stall -> 16 in-order requests.
REQ-039 push 1 in IDLE -> dropped, overflow=1, no mem_req.
REQ-040 push 5 with mem_stall toggling every cycle, eof during stall -> 5 requests in order, done only after last.
REQ-041 rst asserted with 6 queued -> mem_req=0 from next cycle, occupancy 0, new start restarts at base_addr.

Source files
------------

// File: rtl/y_writer.sv
// -----------------------------------------------------------------------------
// y_writer
//
// Collects result values from the intermediator, converts each FloPoCo double
// to IEEE-754 on entry, buffers them in a small FIFO and streams them out as
// sequential 8-byte memory writes starting at a base address latched by
// `start`. A pass runs from `start` until `eof` has been seen and every
// buffered value has been issued, at which point `done` is raised.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   start         one-cycle pulse: latch base_addr, clear counters, enter RUN
//   base_addr     byte address of y[0]
//   push          value on `v` is valid this cycle
//   v             FloPoCo double {exc[1:0], sign, exp[10:0], frac[51:0]}
//   eof           one-cycle pulse: no further push in this pass
//   almost_full   registered back-pressure, occupancy >= AF_THRESHOLD
//   mem_req       write request valid (one cycle per entry)
//   mem_addr      write byte address
//   mem_data      IEEE-754 double to write
//   mem_stall     memory cannot accept a request this cycle
//   rows_written  number of requests issued this pass
//   done          pass complete, held until start or rst
//   overflow      sticky: a push was dropped this pass
// -----------------------------------------------------------------------------
module y_writer #(
  parameter int FIFO_DEPTH      = 16,
  parameter int LOG2_FIFO_DEPTH = 4,
  parameter int AF_THRESHOLD    = 12,
  parameter int ADDR_WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  push,
  input  logic [65:0]           v,
  input  logic                  eof,
  output logic                  almost_full,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_data,
  input  logic                  mem_stall,
  output logic [31:0]           rows_written,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE  = LOG2_FIFO_DEPTH'(1);
  localparam logic [LOG2_FIFO_DEPTH:0]   CNT_ONE  = (LOG2_FIFO_DEPTH + 1)'(1);
  localparam logic [LOG2_FIFO_DEPTH:0]   CNT_FULL = (LOG2_FIFO_DEPTH + 1)'(FIFO_DEPTH);
  localparam logic [LOG2_FIFO_DEPTH:0]   CNT_AF   = (LOG2_FIFO_DEPTH + 1)'(AF_THRESHOLD);

  state_t                     state;
  logic [63:0]                fifo_mem [FIFO_DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr;
  logic [LOG2_FIFO_DEPTH:0]   count;
  logic [LOG2_FIFO_DEPTH:0]   count_next;
  logic [ADDR_WIDTH-1:0]      base_q;
  // Entries popped this pass; drives the address of the request being formed,
  // one cycle ahead of rows_written which counts requests already presented.
  logic [31:0]                pop_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic push_ok;
  logic push_drop;
  logic pop;

  // FloPoCo exception field selects zero / normal / infinity / NaN.
  function automatic logic [63:0] to_ieee(input logic [65:0] f);
    logic [63:0] r;
    case (f[65:64])
      2'b00:   r = {f[63], 63'b0};
      2'b01:   r = f[63:0];
      2'b10:   r = {f[63], 11'h7FF, 52'b0};
      default: r = 64'h7FF8_0000_0000_0000;
    endcase
    return r;
  endfunction

  // Full is judged on pre-pop occupancy, so a push at full is dropped even if
  // a pop frees a slot in the same cycle.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign push_ok    = push && (state == RUN) && !fifo_full;
  assign push_drop  = push && !push_ok;
  assign pop        = !fifo_empty && !mem_stall;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing them is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= to_ieee(v);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      base_q       <= '0;
      pop_cnt      <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      rows_written <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      count       <= count_next;
      almost_full <= (count_next >= CNT_AF);

      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      // Output register: a request is presented for exactly one cycle.
      mem_req <= pop;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        mem_data <= fifo_mem[rd_ptr];
        mem_addr <= base_q + ADDR_WIDTH'({pop_cnt, 3'b000});
        pop_cnt  <= pop_cnt + 32'd1;
      end

      if (mem_req) begin
        rows_written <= rows_written + 32'd1;
      end

      if (push_drop) begin
        overflow <= 1'b1;
      end

      case (state)
        RUN: begin
          if (eof) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          // Finished once nothing is buffered and the last request has left
          // the output register.
          if (fifo_empty && !mem_req) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase

      // A new pass overrides everything above; buffered data is kept.
      if (start) begin
        state        <= RUN;
        base_q       <= base_addr;
        pop_cnt      <= '0;
        rows_written <= '0;
        done         <= 1'b0;
        overflow     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_y_writer.sv
// -----------------------------------------------------------------------------
// tb_y_writer
//
// Self-checking bench for y_writer. A transaction-level reference model (a
// queue of converted values plus pass bookkeeping) is advanced on every
// rising edge from the bench's own inputs; every DUT output is compared with
// the model on the falling edge. Directed steps add constant-valued checks
// for the documented scenarios, followed by randomized passes.
// -----------------------------------------------------------------------------
module tb_y_writer;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AW    = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          push = 1'b0;
  logic [65:0]   v = '0;
  logic          eof = 1'b0;
  logic          mem_stall = 1'b0;
  logic          almost_full;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_data;
  logic [31:0]   rows_written;
  logic          done;
  logic          overflow;

  always #5 clk = ~clk;

  y_writer #(
    .FIFO_DEPTH(DEPTH), .LOG2_FIFO_DEPTH(4), .AF_THRESHOLD(AF), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .push(push), .v(v), .eof(eof), .almost_full(almost_full),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_stall(mem_stall), .rows_written(rows_written), .done(done),
    .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [63:0] ref_conv(input logic [65:0] f);
    logic [63:0] sign_bit;
    sign_bit = {f[63], 63'b0};
    if (f[65:64] == 2'd0) return sign_bit;
    if (f[65:64] == 2'd1) return f[63:0];
    if (f[65:64] == 2'd2) return sign_bit | 64'h7FF0_0000_0000_0000;
    return 64'h7FF8_0000_0000_0000;
  endfunction

  logic [63:0]  q[$];
  int           phase = 0;        // 0 idle, 1 run, 2 flush, 3 done
  logic         m_req = 1'b0;
  logic [63:0]  m_data = '0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_base = '0;
  longint       m_issued = 0;
  logic [31:0]  m_rows = '0;
  logic         m_done = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_af = 1'b0;

  always @(posedge clk) begin
    int pre;
    bit do_pop, acc, old_req;
    if (rst) begin
      q.delete();
      phase = 0; m_req = 0; m_data = '0; m_addr = '0; m_base = '0;
      m_issued = 0; m_rows = '0; m_done = 0; m_ovf = 0; m_af = 0;
    end else begin
      pre     = q.size();
      old_req = m_req;
      do_pop  = (pre > 0) && !mem_stall;
      acc     = push && (phase == 1) && (pre < DEPTH);
      if (push && !acc) m_ovf = 1;
      m_req = do_pop;
      if (do_pop) begin
        m_data = q.pop_front();
        m_addr = m_base + AW'(8 * m_issued);
        m_issued++;
      end
      if (acc) q.push_back(ref_conv(v));
      if (old_req) m_rows = m_rows + 32'd1;
      if (phase == 2 && pre == 0 && !old_req) begin
        phase = 3; m_done = 1;
      end else if (phase == 1 && eof) begin
        phase = 2;
      end
      if (start) begin
        phase = 1; m_base = base_addr; m_issued = 0;
        m_rows = '0; m_done = 0; m_ovf = 0;
      end
      m_af = (q.size() >= AF);
    end
  end

  // -------------------------------------------------------------- monitor
  logic [63:0]   log_data[$];
  logic [AW-1:0] log_addr[$];

  always @(negedge clk) begin
    check("mem_req", 64'(mem_req), 64'(m_req));
    if (m_req) begin
      check("mem_data", mem_data, m_data);
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
    end
    check("rows_written", 64'(rows_written), 64'(m_rows));
    check("done", 64'(done), 64'(m_done));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("almost_full", 64'(almost_full), 64'(m_af));
    if (mem_req === 1'b1) begin
      log_data.push_back(mem_data);
      log_addr.push_back(mem_addr);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic push_val(input logic [65:0] val);
    push = 1'b1; v = val;
    tick();
    push = 1'b0;
  endtask

  function automatic logic [65:0] rnd_val(input logic [1:0] exc);
    return {exc, $urandom(), $urandom()};
  endfunction

  // stall_mode: 0 hold, 1 toggle, 2 random
  task automatic wait_done(input int stall_mode);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      if (stall_mode == 1) mem_stall = ~mem_stall;
      else if (stall_mode == 2) mem_stall = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    mem_stall = 1'b0;
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic end_pass(input int stall_mode);
    eof = 1'b1;
    tick();
    eof = 1'b0;
    wait_done(stall_mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data", mem_data, 64'd0);
    check("rst_rows", 64'(rows_written), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_af", 64'(almost_full), 64'd0);

    // Three normal values, sequential addresses from 0x1000
    log_data.delete(); log_addr.delete();
    do_start(48'h1000);
    for (int i = 0; i < 3; i++) push_val(rnd_val(2'b01));
    end_pass(0);
    check("seq_count", 64'(log_addr.size()), 64'd3);
    check("seq_addr0", 64'(log_addr[0]), 64'h1000);
    check("seq_addr1", 64'(log_addr[1]), 64'h1008);
    check("seq_addr2", 64'(log_addr[2]), 64'h1010);
    check("seq_rows", 64'(rows_written), 64'd3);

    // Special encodings
    log_data.delete(); log_addr.delete();
    do_start(48'h2000);
    push_val({2'b00, 1'b1, 31'($urandom()), $urandom()});
    push_val({2'b10, 1'b0, 31'($urandom()), $urandom()});
    push_val({2'b11, $urandom(), $urandom()});
    end_pass(0);
    check("exc_count", 64'(log_data.size()), 64'd3);
    check("exc00_neg_zero", log_data[0], 64'h8000_0000_0000_0000);
    check("exc10_pos_inf", log_data[1], 64'h7FF0_0000_0000_0000);
    check("exc11_nan", log_data[2], 64'h7FF8_0000_0000_0000);

    // Fill under stall: almost_full, full, overflow, in-order drain
    log_data.delete(); log_addr.delete();
    do_start(48'h3000);
    mem_stall = 1'b1;
    for (int i = 0; i < 12; i++) push_val(rnd_val(2'b01));
    check("af_at_12", 64'(almost_full), 64'd1);
    for (int i = 0; i < 4; i++) push_val(rnd_val(2'b01));
    check("no_ovf_at_16", 64'(overflow), 64'd0);
    push_val(rnd_val(2'b01));
    check("ovf_at_17", 64'(overflow), 64'd1);
    mem_stall = 1'b0;
    end_pass(0);
    check("full_drain_count", 64'(log_data.size()), 64'd16);
    check("full_last_addr", 64'(log_addr[15]), 64'h3078);

    // Push together with pop at full occupancy is still dropped
    log_data.delete(); log_addr.delete();
    do_start(48'h3800);
    mem_stall = 1'b1;
    for (int i = 0; i < 16; i++) push_val(rnd_val(2'b01));
    check("full_no_ovf", 64'(overflow), 64'd0);
    mem_stall = 1'b0;
    push_val(rnd_val(2'b01));
    check("full_push_pop_ovf", 64'(overflow), 64'd1);
    end_pass(0);
    check("full_push_pop_count", 64'(log_data.size()), 64'd16);

    // Push while IDLE is dropped
    rst = 1'b1; tick(); rst = 1'b0;
    log_data.delete(); log_addr.delete();
    push_val(rnd_val(2'b01));
    check("idle_ovf", 64'(overflow), 64'd1);
    repeat (3) tick();
    check("idle_no_req", 64'(log_data.size()), 64'd0);

    // Toggling stall, eof while stalled
    log_data.delete(); log_addr.delete();
    do_start(48'h4000);
    for (int i = 0; i < 5; i++) begin
      mem_stall = i[0];
      push_val(rnd_val(2'b01));
    end
    mem_stall = 1'b1;
    end_pass(1);
    check("toggle_count", 64'(log_data.size()), 64'd5);
    check("toggle_rows", 64'(rows_written), 64'd5);

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      do_start({$urandom(), 16'($urandom())});
      for (int c = 0; c < 40; c++) begin
        mem_stall = ($urandom_range(0, 2) == 0);
        push      = ($urandom_range(0, 9) < 7);
        v         = rnd_val(2'($urandom()));
        tick();
      end
      push = 1'b0;
      end_pass(2);
    end

    // Reset with data queued, then a fresh pass
    do_start(48'h5000);
    mem_stall = 1'b1;
    for (int i = 0; i < 6; i++) push_val(rnd_val(2'b01));
    rst = 1'b1;
    tick();
    check("rst_mid_req", 64'(mem_req), 64'd0);
    rst = 1'b0;
    mem_stall = 1'b0;
    tick();
    check("rst_mid_req_after", 64'(mem_req), 64'd0);
    check("rst_mid_af", 64'(almost_full), 64'd0);
    log_data.delete(); log_addr.delete();
    do_start(48'h6000);
    push_val(rnd_val(2'b01));
    push_val(rnd_val(2'b01));
    end_pass(0);
    check("restart_count", 64'(log_addr.size()), 64'd2);
    check("restart_addr0", 64'(log_addr[0]), 64'h6000);
    check("restart_addr1", 64'(log_addr[1]), 64'h6008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
